// File: rtl/sat_pkg.sv
// Shared encodings for the BCP engine: variable values, literal polarities and
// saturating free-literal count codes.
package sat_pkg;

    localparam logic [1:0] FREE     = 2'b00;
    localparam logic [1:0] FALSE    = 2'b01;
    localparam logic [1:0] TRUE     = 2'b10;
    localparam logic [1:0] CONFLICT = 2'b11;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] NEG   = 2'b01;
    localparam logic [1:0] POS   = 2'b10;

    localparam logic [1:0] CNT0 = 2'b00;
    localparam logic [1:0] CNT1 = 2'b01;
    localparam logic [1:0] CNTN = 2'b11;

    // A negative literal swaps TRUE/FALSE; FREE and CONFLICT map to themselves.
    function automatic logic [1:0] lit_value(input logic [1:0] pol, input logic [1:0] v);
        if (pol == NEG)
            return {v[0], v[1]};
        return v;
    endfunction

endpackage

// File: rtl/free_lit_count.sv
// Saturating merge of one more free literal into a chained 0/1/many count.
module free_lit_count
    import sat_pkg::*;
(
    input  logic [1:0] pre,
    input  logic       free,
    output logic [1:0] next
);

    assign next = {pre[1] | (pre[0] & free), pre[0] | free};

endmodule

// File: rtl/lit_cell.sv
// One literal slot of a clause row: stores polarity, evaluates the literal
// against the variable value and feeds the clause count/sat/implication chains.
module lit_cell
    import sat_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic [2:0] var_value_frombase_i,
    output logic [2:0] var_value_tobase_o,
    input  logic [1:0] freelitcnt_pre,
    output logic [1:0] freelitcnt_next,
    input  logic       imp_drv_i,
    output logic       cclause_o,
    input  logic       cclause_drv_i,
    output logic       clausesat_o
);

    logic [1:0] lit;
    logic [1:0] v;
    logic [1:0] lv;
    logic       active;
    logic       lit_free;
    logic       unused_imp_flag;

    always_ff @(posedge clk) begin
        if (rst)
            lit <= EMPTY;
        else if (wr_i)
            lit <= var_value_frombase_i[2:1];
    end

    assign v               = var_value_frombase_i[2:1];
    assign unused_imp_flag = var_value_frombase_i[0];
    assign lv              = lit_value(lit, v);

    // During a write the bus carries a polarity, not a value, so the cell goes quiet.
    assign active   = ((lit == POS) || (lit == NEG)) && !wr_i;
    assign lit_free = active && (v == FREE);

    free_lit_count u_count (
        .pre  (freelitcnt_pre),
        .free (lit_free),
        .next (freelitcnt_next)
    );

    assign clausesat_o = active && (lv == TRUE);
    assign cclause_o   = cclause_drv_i && active && (lv == FALSE);

    always_comb begin
        var_value_tobase_o = 3'b000;
        if (imp_drv_i && lit_free)
            var_value_tobase_o = {(lit == POS) ? TRUE : FALSE, 1'b1};
    end

endmodule

// File: tb/tb_lit_cell.sv
// Directed bench for lit_cell: hand-computed vectors checked with immediate assertions.
module tb_lit_cell;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_i;
    logic [2:0] var_value_frombase_i;
    logic [2:0] var_value_tobase_o;
    logic [1:0] freelitcnt_pre;
    logic [1:0] freelitcnt_next;
    logic       imp_drv_i;
    logic       cclause_o;
    logic       cclause_drv_i;
    logic       clausesat_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lit_cell dut (
        .clk                  (clk),
        .rst                  (rst),
        .wr_i                 (wr_i),
        .var_value_frombase_i (var_value_frombase_i),
        .var_value_tobase_o   (var_value_tobase_o),
        .freelitcnt_pre       (freelitcnt_pre),
        .freelitcnt_next      (freelitcnt_next),
        .imp_drv_i            (imp_drv_i),
        .cclause_o            (cclause_o),
        .cclause_drv_i        (cclause_drv_i),
        .clausesat_o          (clausesat_o)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs away from the clock edge and let combinational outputs settle.
    task automatic apply(input logic [1:0] v, input logic [1:0] pre,
                         input logic imp, input logic ccd);
        @(negedge clk);
        var_value_frombase_i = {v, 1'b0};
        freelitcnt_pre       = pre;
        imp_drv_i            = imp;
        cclause_drv_i        = ccd;
        #1;
    endtask

    task automatic write_pol(input logic [1:0] pol);
        @(negedge clk);
        wr_i                 = 1'b1;
        var_value_frombase_i = {pol, 1'b0};
        imp_drv_i            = 1'b0;
        cclause_drv_i        = 1'b0;
        @(posedge clk);
        #1;
        wr_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_i = 1'b0; var_value_frombase_i = 3'b000;
        freelitcnt_pre = 2'b00; imp_drv_i = 1'b0; cclause_drv_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: empty slot.
        apply(2'b00, 2'b00, 1'b0, 1'b0);
        check("rst_next", {2'b0, freelitcnt_next}, 4'h0);
        check("rst_tobase", {1'b0, var_value_tobase_o}, 4'h0);
        check("rst_sat", {3'b0, clausesat_o}, 4'h0);
        check("rst_cc", {3'b0, cclause_o}, 4'h0);

        // Positive literal: counting.
        write_pol(2'b10);
        apply(2'b00, 2'b00, 1'b0, 1'b0);
        check("pos_cnt_0to1", {2'b0, freelitcnt_next}, 4'h1);
        apply(2'b01, 2'b01, 1'b0, 1'b0);
        check("pos_notfree_pass", {2'b0, freelitcnt_next}, 4'h1);
        apply(2'b00, 2'b01, 1'b0, 1'b0);
        check("pos_cnt_1to3", {2'b0, freelitcnt_next}, 4'h3);
        apply(2'b00, 2'b11, 1'b0, 1'b0);
        check("pos_cnt_sat", {2'b0, freelitcnt_next}, 4'h3);
        apply(2'b10, 2'b00, 1'b0, 1'b0);
        check("pos_true_sat", {3'b0, clausesat_o}, 4'h1);
        apply(2'b11, 2'b00, 1'b1, 1'b1);
        check("pos_conf_next", {2'b0, freelitcnt_next}, 4'h0);
        check("pos_conf_sat", {3'b0, clausesat_o}, 4'h0);
        check("pos_conf_cc", {3'b0, cclause_o}, 4'h0);
        check("pos_conf_tobase", {1'b0, var_value_tobase_o}, 4'h0);
        apply(2'b01, 2'b00, 1'b0, 1'b1);
        check("pos_cc_on", {3'b0, cclause_o}, 4'h1);
        check("pos_false_sat", {3'b0, clausesat_o}, 4'h0);
        apply(2'b01, 2'b00, 1'b0, 1'b0);
        check("pos_cc_drv_off", {3'b0, cclause_o}, 4'h0);
        apply(2'b00, 2'b00, 1'b0, 1'b1);
        check("pos_cc_free", {3'b0, cclause_o}, 4'h0);
        apply(2'b00, 2'b00, 1'b1, 1'b0);
        check("pos_imp", {1'b0, var_value_tobase_o}, 4'h5);

        // While writing NEG over POS, outputs are quiet even though lv would be FALSE.
        @(negedge clk);
        wr_i = 1'b1; var_value_frombase_i = 3'b010;
        freelitcnt_pre = 2'b01; imp_drv_i = 1'b1; cclause_drv_i = 1'b1;
        #1;
        check("wr_next", {2'b0, freelitcnt_next}, 4'h1);
        check("wr_cc", {3'b0, cclause_o}, 4'h0);
        check("wr_tobase", {1'b0, var_value_tobase_o}, 4'h0);
        check("wr_sat", {3'b0, clausesat_o}, 4'h0);
        @(posedge clk);
        #1 wr_i = 1'b0;

        // Negative literal.
        apply(2'b01, 2'b00, 1'b0, 1'b0);
        check("neg_false_sat", {3'b0, clausesat_o}, 4'h1);
        apply(2'b10, 2'b00, 1'b0, 1'b1);
        check("neg_true_nosat", {3'b0, clausesat_o}, 4'h0);
        check("neg_cc_on", {3'b0, cclause_o}, 4'h1);
        apply(2'b00, 2'b00, 1'b1, 1'b0);
        check("neg_imp", {1'b0, var_value_tobase_o}, 4'h3);
        check("neg_cnt", {2'b0, freelitcnt_next}, 4'h1);
        apply(2'b10, 2'b00, 1'b1, 1'b0);
        check("neg_imp_assigned", {1'b0, var_value_tobase_o}, 4'h0);

        // Clearing the slot.
        write_pol(2'b00);
        apply(2'b00, 2'b01, 1'b1, 1'b1);
        check("clr_next", {2'b0, freelitcnt_next}, 4'h1);
        check("clr_tobase", {1'b0, var_value_tobase_o}, 4'h0);
        check("clr_sat", {3'b0, clausesat_o}, 4'h0);

        // Code 11 behaves as empty.
        write_pol(2'b11);
        apply(2'b00, 2'b00, 1'b1, 1'b0);
        check("pol11_next", {2'b0, freelitcnt_next}, 4'h0);
        check("pol11_tobase", {1'b0, var_value_tobase_o}, 4'h0);
        apply(2'b10, 2'b00, 1'b0, 1'b0);
        check("pol11_sat", {3'b0, clausesat_o}, 4'h0);

        // Reset wins over a simultaneous write.
        write_pol(2'b10);
        @(negedge clk);
        rst = 1'b1; wr_i = 1'b1; var_value_frombase_i = 3'b100;
        @(posedge clk);
        #1 rst = 1'b0; wr_i = 1'b0;
        apply(2'b00, 2'b00, 1'b1, 1'b0);
        check("rstwr_next", {2'b0, freelitcnt_next}, 4'h0);
        check("rstwr_tobase", {1'b0, var_value_tobase_o}, 4'h0);
        apply(2'b10, 2'b00, 1'b0, 1'b0);
        check("rstwr_sat", {3'b0, clausesat_o}, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
